// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the parametrised register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width
//   calc_num_regs()                 : register count derived from the address width
//   RESET_BIT                       : fill value for every state bit at reset
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ADDR_W = 2;

  // Every register and output register clears to all zeros.
  localparam logic RESET_BIT = 1'b0;

  // Every address encoding selects a real register, so the count is a full power of two.
  function automatic int unsigned calc_num_regs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: combinational value select for one read port.
// The selected value is registered by the top level.
// Build option: `define REGFILE_BYPASS_EN to forward same-edge write data to the port.
// Ports:
//   regs    in  NUM_REGS x DATA_W  current storage contents
//   rd_addr in  ADDR_W             read address for this port
//   wr_en   in  1                  write strobe (used only for bypass)
//   wr_addr in  ADDR_W             write address (used only for bypass)
//   wr_data in  DATA_W             write data (used only for bypass)
//   value   out DATA_W             value to capture into this port's output register
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned NUM_REGS = calc_num_regs(ADDR_W)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               rd_addr,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               value
);

  logic addr_is_zero;
  logic bypass_hit;

  assign addr_is_zero = (rd_addr == '0);

`ifdef REGFILE_BYPASS_EN
  // A write dropped by the zero register needs no separate test here: the
  // zero-register select below takes priority over the bypass.
  assign bypass_hit = wr_en && (wr_addr == rd_addr);
`else
  assign bypass_hit = 1'b0;

  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    // NOTE: the default assignment comes first, so every path drives value and no latch is inferred.
    value = regs[rd_addr];
    if (ZERO_REG && addr_is_zero) begin
      value = '0;
    end else if (bypass_hit) begin
      value = wr_data;
    end
  end

endmodule

// File: rtl/regfile_nport.sv
// regfile_nport: parametrised register file with two registered read ports,
// one synchronous write port, and a destination-field pass-through.
// Build option: `define REGFILE_BYPASS_EN makes a same-edge write visible to a read of the same address.
// Parameters: DATA_W (register width), ADDR_W (address width, NUM_REGS = 2**ADDR_W),
//             ZERO_REG (1 = register 0 reads as zero and ignores writes).
// Ports:
//   clk      in  1       rising-edge clock
//   rst_n    in  1       asynchronous active-low reset
//   rd_en    in  1       capture a read of both ports this cycle
//   ra_addr  in  ADDR_W  port A read address
//   rb_addr  in  ADDR_W  port B read address
//   dest_in  in  ADDR_W  destination field, registered along with the reads
//   wr_en    in  1       write strobe
//   wr_addr  in  ADDR_W  write address
//   wr_data  in  DATA_W  write data
//   ra_data  out DATA_W  registered port A data
//   rb_data  out DATA_W  registered port B data
//   dest_out out ADDR_W  registered dest_in
//   rd_valid out 1       one-cycle strobe: ra_data/rb_data/dest_out were just updated
module regfile_nport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [ADDR_W-1:0] dest_out,
  output logic              rd_valid
);

  localparam int unsigned NUM_REGS = calc_num_regs(ADDR_W);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]               ra_value;
  logic [DATA_W-1:0]               rb_value;
  logic                            wr_accept;

  // With the zero register enabled, writes to address 0 are discarded.
  assign wr_accept = wr_en && !(ZERO_REG && (wr_addr == '0));

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rdport_a (
    .regs   (regs),
    .rd_addr(ra_addr),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .value  (ra_value)
  );

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rdport_b (
    .regs   (regs),
    .rd_addr(rb_addr),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .value  (rb_value)
  );

  // NOTE: the storage array is inside the async reset on purpose: the register file
  // must read back all zeros after reset, so it is built from flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= {NUM_REGS{{DATA_W{RESET_BIT}}}};
    end else if (wr_accept) begin
      // NOTE: sequential state uses non-blocking assignments, so the read ports on
      // this edge still see the contents from before the write.
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data  <= {DATA_W{RESET_BIT}};
      rb_data  <= {DATA_W{RESET_BIT}};
      dest_out <= {ADDR_W{RESET_BIT}};
      rd_valid <= RESET_BIT;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        ra_data  <= ra_value;
        rb_data  <= rb_value;
        dest_out <= dest_in;
      end
    end
  end

endmodule

// File: tb/tb_regfile_nport.sv
// tb_regfile_nport: scoreboard bench for regfile_nport.
// Instance u_dut0 uses the default build (8-bit data, 4 registers, no zero register).
// Instance u_dut1 uses 16-bit data, 8 registers and a zero register.
// Expected read results are queued when a read is issued; a monitor per instance
// pops and compares whenever rd_valid is high.
module tb_regfile_nport;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance 0 signals
  logic       rd_en0, we0, valid0;
  logic [1:0] ra0, rb0, dest_in0, wa0, dest_out0;
  logic [7:0] wd0, ra_data0, rb_data0;

  // Instance 1 signals
  logic        rd_en1, we1, valid1;
  logic [2:0]  ra1, rb1, dest_in1, wa1, dest_out1;
  logic [15:0] wd1, ra_data1, rb_data1;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  regfile_nport u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en0),
    .ra_addr (ra0),
    .rb_addr (rb0),
    .dest_in (dest_in0),
    .wr_en   (we0),
    .wr_addr (wa0),
    .wr_data (wd0),
    .ra_data (ra_data0),
    .rb_data (rb_data0),
    .dest_out(dest_out0),
    .rd_valid(valid0)
  );

  regfile_nport #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .ZERO_REG(1'b1)
  ) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en1),
    .ra_addr (ra1),
    .rb_addr (rb1),
    .dest_in (dest_in1),
    .wr_en   (we1),
    .wr_addr (wa1),
    .wr_data (wd1),
    .ra_data (ra_data1),
    .rb_data (rb_data1),
    .dest_out(dest_out1),
    .rd_valid(valid1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle on instance 0: drive, take the edge, queue the expected read result.
  task automatic step0(input bit we, input logic [1:0] wa, input logic [7:0] wd,
                       input bit re, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] dest, input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    we0 = we; wa0 = wa; wd0 = wd;
    rd_en0 = re; ra0 = ra; rb0 = rb; dest_in0 = dest;
    @(posedge clk);
    if (re) begin
      e.ra = {8'h00, ea};
      e.rb = {8'h00, eb};
      e.dest = {1'b0, dest};
      q0.push_back(e);
    end
    #1;
    we0 = 1'b0; rd_en0 = 1'b0;
  endtask

  task automatic step1(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                       input bit re, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] dest, input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    we1 = we; wa1 = wa; wd1 = wd;
    rd_en1 = re; ra1 = ra; rb1 = rb; dest_in1 = dest;
    @(posedge clk);
    if (re) begin
      e.ra = ea;
      e.rb = eb;
      e.dest = dest;
      q1.push_back(e);
    end
    #1;
    we1 = 1'b0; rd_en1 = 1'b0;
  endtask

  task automatic check_hold0(input string tag);
    check({tag, " ra_data"}, 32'(ra_data0), 32'h5C);
    check({tag, " rb_data"}, 32'(rb_data0), 32'h77);
    check({tag, " dest_out"}, 32'(dest_out0), 32'd1);
    check({tag, " rd_valid"}, 32'(valid0), 32'd0);
  endtask

  // Monitors: a read issued at edge N must show rd_valid after edge N, no sooner or later.
  always @(negedge clk) begin
    exp_t e;
    if (valid0) begin
      if (q0.size() == 0) begin
        check("p0 spurious rd_valid", 32'(valid0), 32'd0);
      end else begin
        e = q0.pop_front();
        check("p0 ra_data", 32'(ra_data0), 32'(e.ra));
        check("p0 rb_data", 32'(rb_data0), 32'(e.rb));
        check("p0 dest_out", 32'(dest_out0), 32'(e.dest));
      end
    end else if (q0.size() != 0) begin
      check("p0 rd_valid missing", 32'(valid0), 32'd1);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) begin
        check("p1 spurious rd_valid", 32'(valid1), 32'd0);
      end else begin
        e = q1.pop_front();
        check("p1 ra_data", 32'(ra_data1), 32'(e.ra));
        check("p1 rb_data", 32'(rb_data1), 32'(e.rb));
        check("p1 dest_out", 32'(dest_out1), 32'(e.dest));
      end
    end else if (q1.size() != 0) begin
      check("p1 rd_valid missing", 32'(valid1), 32'd1);
      void'(q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rd_en0 = 1'b0; we0 = 1'b0; ra0 = '0; rb0 = '0; dest_in0 = '0; wa0 = '0; wd0 = '0;
    rd_en1 = 1'b0; we1 = 1'b0; ra1 = '0; rb1 = '0; dest_in1 = '0; wa1 = '0; wd1 = '0;

    #2;
    check("reset ra_data", 32'(ra_data0), 32'd0);
    check("reset rb_data", 32'(rb_data0), 32'd0);
    check("reset dest_out", 32'(dest_out0), 32'd0);
    check("reset rd_valid", 32'(valid0), 32'd0);
    check("reset p1 rd_valid", 32'(valid1), 32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- Instance 0: 8-bit, 4 registers ----
    // Write then read on the following edge.
    step0(1'b1, 2'd1, 8'h5C, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3, 2'd2, 8'h5C, 8'h00);
    step0(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);

    // Same-edge write and read of reg 3, then the same address on both ports.
    step0(1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
    step0(1'b1, 2'd3, 8'h22, 1'b1, 2'd3, 2'd1, 2'd1, BYP ? 8'h22 : 8'h11, 8'h5C);
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd3, 8'h22, 8'h22);

    // Back-to-back reads, one with an unrelated write on the same edge.
    step0(1'b1, 2'd2, 8'h77, 1'b1, 2'd0, 2'd1, 2'd0, 8'h00, 8'h5C);
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3, 2'd2, 8'h77, 8'h22);
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 2'd1, 8'h5C, 8'h77);

    // Hold: three idle read cycles while the registers and addresses change.
    step0(1'b1, 2'd1, 8'hA1, 1'b0, 2'd2, 2'd0, 2'd3, 8'h00, 8'h00);
    check_hold0("hold1");
    step0(1'b1, 2'd2, 8'hB2, 1'b0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00);
    check_hold0("hold2");
    step0(1'b1, 2'd3, 8'hC3, 1'b0, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00);
    check_hold0("hold3");
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 2'd2, 8'hA1, 8'hB2);
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 2'd3, 8'hC3, 8'h00);

    // Mid-run reset after writing 8'hAA to reg 2.
    step0(1'b1, 2'd2, 8'hAA, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 2'd3, 8'hAA, 8'hAA);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset ra_data", 32'(ra_data0), 32'd0);
    check("midreset rb_data", 32'(rb_data0), 32'd0);
    check("midreset dest_out", 32'(dest_out0), 32'd0);
    check("midreset rd_valid", 32'(valid0), 32'd0);
    // A write and read offered while reset is held must be ignored.
    we0 = 1'b1; wa0 = 2'd1; wd0 = 8'hEE;
    rd_en0 = 1'b1; ra0 = 2'd1; rb0 = 2'd2; dest_in0 = 2'd3;
    @(posedge clk);
    #1;
    check("inreset ra_data", 32'(ra_data0), 32'd0);
    check("inreset dest_out", 32'(dest_out0), 32'd0);
    check("inreset rd_valid", 32'(valid0), 32'd0);
    we0 = 1'b0; rd_en0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step0(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd1, 2'd0, 8'h00, 8'h00);
    step0(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);

    // ---- Instance 1: 16-bit, 8 registers, zero register ----
    step1(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000);
    step1(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000);
    step1(1'b1, 3'd4, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000);
    step1(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd4, 3'd5, 16'hBEEF, 16'h1234);
    step1(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd7, 3'd0, 16'h0000, 16'hBEEF);
    // Same-edge write to the zero register never leaks through.
    step1(1'b1, 3'd0, 16'hABCD, 1'b1, 3'd0, 3'd0, 3'd1, 16'h0000, 16'h0000);
    // Same-edge write to reg 4 on a wide instance.
    step1(1'b1, 3'd4, 16'h5555, 1'b1, 3'd4, 3'd7, 3'd6, BYP ? 16'h5555 : 16'h1234, 16'hBEEF);
    step1(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd0, 3'd2, 16'h5555, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    check("p0 queue drained", 32'(q0.size()), 32'd0);
    check("p1 queue drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
